// File: rtl/mm_burst_reader_pkg.sv
// Shared types and constants for the Avalon-MM burst read master.
// Holds the FSM state enum, the word size in bytes and the default maximum burst length.
package mm_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE
  } state_e;

  localparam int WORD_BYTES        = 4;
  localparam int DEFAULT_MAX_BURST = 16;

endpackage

// File: rtl/mm_burst_reader_if.sv
// Avalon-MM read channel between the burst reader (master) and the memory bridge (slave).
// Byte addressing; burstcount counts words.
interface mm_burst_reader_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
) ();

  logic               read;
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output read, address, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, address, burstcount,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/mm_burst_reader_sizer.sv
// Picks the next burst length, min(MAX_BURST, remaining), and reports whether
// the downstream FIFO currently has room for the whole burst.
module mm_burst_sizer #(
  parameter int MAX_BURST = 16,
  parameter int SPACE_W   = 11,
  parameter int BURST_W   = $clog2(MAX_BURST) + 1
) (
  input  logic [15:0]        remaining_i,
  input  logic [SPACE_W-1:0] fifo_space_i,
  output logic [BURST_W-1:0] burst_o,
  output logic               space_ok_o
);

  localparam logic [15:0] MAX_WORDS = 16'(MAX_BURST);

  // NOTE: assigning a default before the conditional keeps always_comb free of inferred latches.
  always_comb begin
    burst_o = BURST_W'(MAX_BURST);
    if (remaining_i < MAX_WORDS) begin
      burst_o = remaining_i[BURST_W-1:0];
    end
  end

  assign space_ok_o = 32'(fifo_space_i) >= 32'(burst_o);

endmodule

// File: rtl/mm_burst_reader.sv
// Avalon-MM burst read master: fetches a packet in FIFO-sized bursts and streams the beats downstream.
// Define MM_BURST_READER_STATS_EN to build the busy-cycle counter driven onto stat_cycles.
module mm_burst_reader
  import mm_reader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int SPACE_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  read_address,
  input  logic [31:0]        pkt_begin,
  input  logic [31:0]        pkt_end,
  output logic               busy,
  output logic               done,
  input  logic [SPACE_W-1:0] fifo_space,
  output logic               fifo_wr,
  output logic [DATA_W-1:0]  fifo_data,
  mm_burst_reader_if.master  avm,
  output logic [31:0]        stat_cycles
);

  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               read_q;
  logic               fifo_wr_q;
  logic [DATA_W-1:0]  fifo_data_q;
  logic [ADDR_W-1:0]  address_q;
  logic [BURST_W-1:0] burstcount_q;
  logic [BURST_W-1:0] beats_left_q;
  logic [15:0]        remaining_q;

  logic [31:0]        span_d;
  logic [15:0]        length_d;
  logic               empty_d;
  logic [BURST_W-1:0] burst_d;
  logic               space_ok_d;
  logic               unused_bits;

  assign span_d      = pkt_end - pkt_begin;
  assign length_d    = span_d[17:2];
  assign empty_d     = (pkt_end <= pkt_begin) || (length_d == '0);
  assign unused_bits = ^{span_d[31:18], span_d[1:0], read_address[1:0]};

  mm_burst_sizer #(
    .MAX_BURST (MAX_BURST),
    .SPACE_W   (SPACE_W),
    .BURST_W   (BURST_W)
  ) u_sizer (
    .remaining_i  (remaining_q),
    .fifo_space_i (fifo_space),
    .burst_o      (burst_d),
    .space_ok_o   (space_ok_d)
  );

  // NOTE: non-blocking assignments so every register in this block samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      read_q       <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_data_q  <= '0;
      address_q    <= '0;
      burstcount_q <= '0;
      beats_left_q <= '0;
      remaining_q  <= '0;
    end else begin
      fifo_wr_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            address_q   <= {read_address[ADDR_W-1:2], 2'b00};
            remaining_q <= length_d;
            busy_q      <= 1'b1;
            state_q     <= empty_d ? DONE : ISSUE;
          end
        end
        // Once raised, read is held until accepted, whatever fifo_space does.
        ISSUE: begin
          if (read_q) begin
            if (!avm.waitrequest) begin
              read_q       <= 1'b0;
              beats_left_q <= burstcount_q;
              state_q      <= WAIT_DATA;
            end
          end else if (space_ok_d) begin
            read_q       <= 1'b1;
            burstcount_q <= burst_d;
          end
        end
        WAIT_DATA: begin
          if (avm.readdatavalid) begin
            fifo_wr_q    <= 1'b1;
            fifo_data_q  <= avm.readdata;
            beats_left_q <= beats_left_q - BURST_W'(1);
            remaining_q  <= remaining_q - 16'd1;
            if (beats_left_q == BURST_W'(1)) begin
              if (remaining_q == 16'd1) begin
                state_q <= DONE;
              end else begin
                address_q <= address_q + ADDR_W'(burstcount_q) * ADDR_W'(WORD_BYTES);
                state_q   <= ISSUE;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MM_BURST_READER_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else if (state_q == IDLE && start) begin
      stat_q <= '0;
    end else if (busy_q) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_cycles = stat_q;
`else
  assign stat_cycles = '0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign fifo_wr        = fifo_wr_q;
  assign fifo_data      = fifo_data_q;
  assign avm.read       = read_q;
  assign avm.address    = address_q;
  assign avm.burstcount = burstcount_q;

endmodule

// File: tb/tb_mm_burst_reader.sv
// Scoreboard bench for mm_burst_reader: directed packets, an Avalon slave model with
// programmable waitrequest stalls, and a negedge monitor that pops expected bursts and beats.
module tb_mm_burst_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] read_address;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic        busy;
  logic        done;
  logic [10:0] fifo_space;
  logic        fifo_wr;
  logic [31:0] fifo_data;
  logic [31:0] stat_cycles;

  mm_burst_reader_if #(.ADDR_W(32), .DATA_W(32), .BURST_W(5)) avm ();

  mm_burst_reader #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_BURST (16),
    .SPACE_W   (11)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .read_address (read_address),
    .pkt_begin    (pkt_begin),
    .pkt_end      (pkt_end),
    .busy         (busy),
    .done         (done),
    .fifo_space   (fifo_space),
    .fifo_wr      (fifo_wr),
    .fifo_data    (fifo_data),
    .avm          (avm),
    .stat_cycles  (stat_cycles)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          acc_cnt = 0;
  int          last_wr_cyc = 0;
  int          wait_n = 0;
  bit          mon_en = 0;
  logic [31:0] exp_data[$];
  logic [36:0] exp_burst[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Avalon slave: stalls each new request for wait_n cycles, then returns full-rate beats.
  initial begin : avalon_slave
    int          beats_pend;
    int          hold_cnt;
    logic [31:0] beat_addr;
    beats_pend = 0;
    hold_cnt   = 0;
    beat_addr  = '0;
    avm.waitrequest   = 1'b0;
    avm.readdatavalid = 1'b0;
    avm.readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      avm.readdatavalid = 1'b0;
      if (beats_pend > 0) begin
        avm.readdatavalid = 1'b1;
        avm.readdata      = mem_word(beat_addr);
        beat_addr         = beat_addr + 32'd4;
        beats_pend--;
      end else if (avm.read === 1'b1) begin
        if (hold_cnt < wait_n) begin
          avm.waitrequest = 1'b1;
          hold_cnt++;
        end else begin
          avm.waitrequest = 1'b0;
          hold_cnt   = 0;
          beats_pend = int'(avm.burstcount);
          beat_addr  = avm.address;
        end
      end
    end
  end

  // Monitor: compares FIFO writes and accepted bursts against the scoreboard queues.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_addr;
  logic [4:0]  prev_bc;
  logic [31:0] exp_w;
  logic [36:0] exp_b;

  always @(negedge clk) begin
    if (mon_en) begin
      if (fifo_wr) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        check("fifo_wr_expected", 64'(exp_data.size() != 0), 64'd1);
        if (exp_data.size() != 0) begin
          exp_w = exp_data.pop_front();
          check("fifo_data", fifo_data, exp_w);
        end
      end
      if (hold_prev) begin
        check("stall_read_held", avm.read, 1);
        check("stall_address_stable", avm.address, prev_addr);
        check("stall_burstcount_stable", avm.burstcount, prev_bc);
      end
      hold_prev = avm.read && avm.waitrequest;
      prev_addr = avm.address;
      prev_bc   = avm.burstcount;
      if (avm.read && !avm.waitrequest) begin
        acc_cnt++;
        check("burst_expected", 64'(exp_burst.size() != 0), 64'd1);
        if (exp_burst.size() != 0) begin
          exp_b = exp_burst.pop_front();
          check("burst_address", avm.address, exp_b[36:5]);
          check("burstcount", avm.burstcount, exp_b[4:0]);
        end
      end
    end
  end

  // mode 0: plain; mode 1: start with too little FIFO space, then release; mode 2: drop space after read.
  task automatic run_pkt(input string tag, input logic [31:0] ra, input logic [31:0] pb,
                         input logic [31:0] pe, input int wn, input logic [10:0] space,
                         input int mode);
    logic [31:0] span;
    logic [31:0] a;
    logic [31:0] stat_exp;
    int len, rem, bc, nb, c0, k, acc0, wr0;
    span = pe - pb;
    len  = (pe > pb) ? int'(span[17:2]) : 0;
    a    = {ra[31:2], 2'b00};
    rem  = len;
    nb   = 0;
    while (rem > 0) begin
      bc = (rem > 16) ? 16 : rem;
      exp_burst.push_back({a, 5'(bc)});
      for (int i = 0; i < bc; i++) exp_data.push_back(mem_word(a + 32'(4 * i)));
      a   = a + 32'(4 * bc);
      rem = rem - bc;
      nb++;
    end

    wait_n       = wn;
    fifo_space   = space;
    read_address = ra;
    pkt_begin    = pb;
    pkt_end      = pe;
    acc0         = acc_cnt;
    wr0          = wr_cnt;
    start        = 1'b1;
    c0           = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ":busy_rise"}, busy, 1);

    if (mode == 1) begin
      for (int i = 0; i < 6; i++) begin
        check({tag, ":read_blocked"}, avm.read, 0);
        @(posedge clk);
        #1;
      end
      fifo_space = 11'd16;
      @(posedge clk);
      #1;
      check({tag, ":read_after_space"}, avm.read, 1);
    end else if (mode == 2) begin
      k = 0;
      while (avm.read !== 1'b1 && k < 50) begin
        @(posedge clk);
        #1;
        k++;
      end
      check({tag, ":read_seen"}, avm.read, 1);
      fifo_space = 11'd0;
    end

    k = 0;
    while (done !== 1'b1 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, ":done_seen"}, done, 1);
    if (len == 0) check({tag, ":done_latency"}, 64'(cyc), 64'(c0 + 2));
    else          check({tag, ":done_after_last_wr"}, 64'(cyc), 64'(last_wr_cyc + 1));
    check({tag, ":busy_low"}, busy, 0);
    check({tag, ":bursts"}, 64'(acc_cnt - acc0), 64'(nb));
    check({tag, ":words"}, 64'(wr_cnt - wr0), 64'(len));
    check({tag, ":data_drained"}, 64'(exp_data.size()), 64'd0);
`ifdef MM_BURST_READER_STATS_EN
    stat_exp = 32'(cyc - c0 - 1);
`else
    stat_exp = 32'd0;
`endif
    check({tag, ":stat_cycles"}, stat_cycles, stat_exp);
    @(posedge clk);
    #1;
    check({tag, ":done_single"}, done, 0);
    check({tag, ":stat_hold"}, stat_cycles, stat_exp);
  endtask

  task automatic reset_mid_burst();
    int k, wr0;
    exp_burst.push_back({32'h0000_2000, 5'd16});
    for (int i = 0; i < 16; i++) exp_data.push_back(mem_word(32'h2000 + 32'(4 * i)));
    wait_n       = 0;
    fifo_space   = 11'd100;
    read_address = 32'h2000;
    pkt_begin    = 32'h0;
    pkt_end      = 32'd64;
    wr0          = wr_cnt;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (wr_cnt < wr0 + 5 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst:beats_before_reset", 64'(wr_cnt >= wr0 + 5), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst:fifo_wr", fifo_wr, 0);
    check("rst:busy", busy, 0);
    check("rst:read", avm.read, 0);
    check("rst:stat_cycles", stat_cycles, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_data.delete();
    exp_burst.delete();
    wr0 = wr_cnt;
    repeat (25) @(posedge clk);
    #1;
    check("rst:no_wr_after_reset", 64'(wr_cnt - wr0), 64'd0);
    check("rst:idle_busy", busy, 0);
    check("rst:idle_stat", stat_cycles, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    read_address = '0;
    pkt_begin    = '0;
    pkt_end      = '0;
    fifo_space   = 11'd100;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    check("reset:read", avm.read, 0);
    check("reset:address", avm.address, 0);
    check("reset:burstcount", avm.burstcount, 0);
    check("reset:fifo_wr", fifo_wr, 0);
    check("reset:fifo_data", fifo_data, 0);
    check("reset:busy", busy, 0);
    check("reset:done", done, 0);
    check("reset:stat_cycles", stat_cycles, 0);

    run_pkt("p64",     32'h0000_1000, 32'h0,   32'd64,  0, 11'd100, 0);
    run_pkt("p160",    32'h0000_4003, 32'h100, 32'h1A0, 0, 11'd100, 0);
    run_pkt("space",   32'h0000_8000, 32'h0,   32'd64,  0, 11'd8,   1);
    run_pkt("wait3",   32'h0000_C000, 32'h0,   32'd64,  3, 11'd100, 2);
    run_pkt("zero_eq", 32'h0000_0100, 32'h80,  32'h80,  0, 11'd100, 0);
    run_pkt("zero_lt", 32'h0000_0100, 32'h80,  32'h40,  0, 11'd100, 0);
    run_pkt("zero_sub",32'h0000_0100, 32'h80,  32'h83,  0, 11'd100, 0);
    run_pkt("wrap",    32'hFFFF_FFC0, 32'h0,   32'd128, 0, 11'd100, 0);
    reset_mid_burst();
    run_pkt("cold",    32'h0000_2000, 32'h0,   32'd64,  0, 11'd100, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
